// File: rtl/ind_arb_if.sv
// Indicator arbiter bus: per-channel requests/flags plus the single ind/status handshake.
// The slave modport is the arbiter side; master is the requester/interface side.
interface ind_arb_if #(
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned CH_W   = $clog2(NUM_CH)
) ();
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] pend;
  logic              ind;
  logic [CH_W-1:0]   ind_ch;
  logic              status;
  logic              done;
  logic [CH_W-1:0]   done_ch;
  logic [NUM_CH-1:0] err;
  logic [NUM_CH-1:0] err_clr;

  modport slave (
    input  req, status, err_clr,
    output pend, ind, ind_ch, done, done_ch, err
  );

  modport master (
    output req, status, err_clr,
    input  pend, ind, ind_ch, done, done_ch, err
  );
endinterface

// File: rtl/ind_arb.sv
// N-channel indicator arbiter: sticky pending bits, fixed/round-robin grant, four-phase ind/status.
// Define IND_ARB_TIMEOUT_EN to enable the ACTIVE-state timeout that aborts into sticky err flags.
module ind_arb #(
  parameter int unsigned NUM_CH      = 3,
  parameter int unsigned CH_W        = $clog2(NUM_CH),
  parameter int unsigned ARB_MODE    = 0,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic       clk,
  input  logic       rst,
  ind_arb_if.slave   bus
);

  typedef enum logic [1:0] {StIdle, StActive, StRelease} state_e;

  localparam logic [7:0] TimeoutLim = 8'(TIMEOUT_CYC - 1);

  state_e            state_q;
  logic [CH_W-1:0]   rr_ptr_q;
  logic [CH_W-1:0]   win;
  logic              complete;
  logic              abort;
  logic [NUM_CH-1:0] clr_mask;

  // Scan from the start pointer upward with wrap; first pending channel wins.
  always_comb begin
    logic [CH_W:0] start;
    logic [CH_W:0] sum;
    logic          found;
    win   = '0;
    found = 1'b0;
    start = (ARB_MODE == 1) ? {1'b0, rr_ptr_q} : '0;
    sum   = '0;
    for (int k = 0; k < int'(NUM_CH); k++) begin
      sum = start + (CH_W+1)'(k);
      if (sum >= (CH_W+1)'(NUM_CH)) begin
        sum = sum - (CH_W+1)'(NUM_CH);
      end
      if (!found && bus.pend[sum[CH_W-1:0]]) begin
        win   = sum[CH_W-1:0];
        found = 1'b1;
      end
    end
  end

`ifdef IND_ARB_TIMEOUT_EN
  logic [7:0] cnt_q;
  assign abort = (state_q == StActive) && !bus.status && (cnt_q == TimeoutLim);
`else
  assign abort = 1'b0;
`endif

  assign complete = (state_q == StActive) && bus.status;

  always_comb begin
    clr_mask = '0;
    if (complete || abort) begin
      clr_mask[bus.ind_ch] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      bus.pend    <= '0;
      bus.ind     <= 1'b0;
      bus.ind_ch  <= '0;
      bus.done    <= 1'b0;
      bus.done_ch <= '0;
`ifdef IND_ARB_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      // A new request on the channel being retired wins over its clear.
      bus.pend <= (bus.pend & ~clr_mask) | bus.req;
      bus.done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (|bus.pend) begin
            bus.ind    <= 1'b1;
            bus.ind_ch <= win;
            rr_ptr_q   <= (win == CH_W'(NUM_CH - 1)) ? '0 : win + 1'b1;
            state_q    <= StActive;
`ifdef IND_ARB_TIMEOUT_EN
            cnt_q      <= '0;
`endif
          end
        end
        StActive: begin
          if (complete) begin
            bus.ind     <= 1'b0;
            bus.done    <= 1'b1;
            bus.done_ch <= bus.ind_ch;
            state_q     <= StRelease;
          end else if (abort) begin
            bus.ind <= 1'b0;
            state_q <= StRelease;
          end else begin
`ifdef IND_ARB_TIMEOUT_EN
            cnt_q <= cnt_q + 8'd1;
`endif
          end
        end
        StRelease: begin
          if (!bus.status) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef IND_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.err <= '0;
    end else begin
      bus.err <= (bus.err & ~bus.err_clr) | (abort ? clr_mask : '0);
    end
  end
`else
  assign bus.err = '0;
  logic unused_cfg;
  assign unused_cfg = ^{bus.err_clr, TimeoutLim};
`endif

endmodule

// File: tb/tb_ind_arb.sv
// Directed bench for ind_arb: a fixed-priority and a round-robin instance, with grant/done
// scoreboards filled at stimulus time and drained by a negedge monitor.
module tb_ind_arb;
  localparam int unsigned N = 3;
  localparam int unsigned W = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ind_arb_if #(.NUM_CH(N), .CH_W(W)) fa ();
  ind_arb_if #(.NUM_CH(N), .CH_W(W)) ra ();

  ind_arb #(.NUM_CH(N), .CH_W(W), .ARB_MODE(0), .TIMEOUT_CYC(4)) u_fix (
    .clk (clk),
    .rst (rst),
    .bus (fa.slave)
  );

  ind_arb #(.NUM_CH(N), .CH_W(W), .ARB_MODE(1), .TIMEOUT_CYC(4)) u_rr (
    .clk (clk),
    .rst (rst),
    .bus (ra.slave)
  );

  int total = 0;
  int bad   = 0;

  logic [W-1:0] qfg[$];
  logic [W-1:0] qfd[$];
  logic [W-1:0] qrg[$];
  logic [W-1:0] qrd[$];

  // status is either driven by hand or echoes ind one cycle late
  logic f_echo = 1'b0, r_echo = 1'b0;
  logic f_man = 1'b0, r_man = 1'b0;
  logic f_eq = 1'b0, r_eq = 1'b0;
  logic f_seen = 1'b0, r_seen = 1'b0;
  assign fa.status = f_echo ? f_eq : f_man;
  assign ra.status = r_echo ? r_eq : r_man;

  always @(negedge clk) begin
    f_eq   = f_seen;
    f_seen = fa.ind;
    r_eq   = r_seen;
    r_seen = ra.ind;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic f_ip = 1'b0, f_dp = 1'b0, r_ip = 1'b0, r_dp = 1'b0;
  logic [W-1:0] f_chp = '0, r_chp = '0;

  always @(negedge clk) begin
    if (fa.ind === 1'b1 && !f_ip) begin
      chk("fix_grant_expected", 32'(qfg.size() != 0), 1);
      if (qfg.size() != 0) chk("fix_grant_ch", fa.ind_ch, qfg.pop_front());
    end
    if (fa.ind === 1'b1 && f_ip) chk("fix_ind_ch_stable", fa.ind_ch, f_chp);
    if (fa.done === 1'b1) begin
      chk("fix_done_one_cycle", f_dp, 0);
      chk("fix_done_expected", 32'(qfd.size() != 0), 1);
      if (qfd.size() != 0) chk("fix_done_ch", fa.done_ch, qfd.pop_front());
    end
    if (ra.ind === 1'b1 && !r_ip) begin
      chk("rr_grant_expected", 32'(qrg.size() != 0), 1);
      if (qrg.size() != 0) chk("rr_grant_ch", ra.ind_ch, qrg.pop_front());
    end
    if (ra.done === 1'b1) begin
      chk("rr_done_expected", 32'(qrd.size() != 0), 1);
      if (qrd.size() != 0) chk("rr_done_ch", ra.done_ch, qrd.pop_front());
    end
    f_ip  = (fa.ind === 1'b1);
    f_dp  = (fa.done === 1'b1);
    f_chp = fa.ind_ch;
    r_ip  = (ra.ind === 1'b1);
    r_dp  = (ra.done === 1'b1);
    r_chp = ra.ind_ch;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hi;
    fa.req = '0; fa.err_clr = '0;
    ra.req = '0; ra.err_clr = '0;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    chk("rst_fix_pend", fa.pend, 0);
    chk("rst_fix_ind", fa.ind, 0);
    chk("rst_fix_ind_ch", fa.ind_ch, 0);
    chk("rst_fix_done", fa.done, 0);
    chk("rst_fix_done_ch", fa.done_ch, 0);
    chk("rst_fix_err", fa.err, 0);
    chk("rst_rr_pend", ra.pend, 0);
    chk("rst_rr_ind", ra.ind, 0);
    chk("rst_rr_done", ra.done, 0);
    chk("rst_rr_err", ra.err, 0);

    // Fixed priority, simultaneous one-cycle pulse on ch1/ch2
    f_echo = 1'b1;
    fa.req = 3'b110;
    qfg.push_back(2'd1); qfg.push_back(2'd2);
    qfd.push_back(2'd1); qfd.push_back(2'd2);
    tick(1);
    fa.req = '0;
    chk("t1_pend_set", fa.pend, 3'b110);
    chk("t1_ind_latency", fa.ind, 0);
    tick(1);
    chk("t1_ind_up", fa.ind, 1);
    chk("t1_ind_ch", fa.ind_ch, 1);
    tick(20);
    chk("t1_pend_clear", fa.pend, 0);
    chk("t1_grants_left", qfg.size(), 0);
    chk("t1_dones_left", qfd.size(), 0);

    // Round-robin with all requests held
    r_echo = 1'b1;
    ra.req = 3'b111;
    for (int i = 0; i < 8; i++) begin
      qrg.push_back(2'(i % 3));
      qrd.push_back(2'(i % 3));
    end
    for (int i = 0; i < 60; i++) begin
      tick(1);
      if (qrg.size() <= 2) break;
    end
    ra.req = '0;
    tick(30);
    chk("t2_grants_left", qrg.size(), 0);
    chk("t2_dones_left", qrd.size(), 0);
    chk("t2_pend_clear", ra.pend, 0);

    // Re-request on ch0 in the cycle its status is sampled high
    fa.req = 3'b001;
    qfg.push_back(2'd0); qfd.push_back(2'd0);
    tick(1);
    fa.req = '0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (fa.ind === 1'b1) break;
    end
    chk("t3_ind_up", fa.ind, 1);
    tick(1);
    fa.req = 3'b001;
    qfg.push_back(2'd0); qfd.push_back(2'd0);
    tick(1);
    fa.req = '0;
    chk("t3_done", fa.done, 1);
    chk("t3_pend_kept", fa.pend[0], 1);
    chk("t3_ind_down", fa.ind, 0);
    tick(20);
    chk("t3_grants_left", qfg.size(), 0);
    chk("t3_dones_left", qfd.size(), 0);
    chk("t3_pend_clear", fa.pend, 0);

    // Four-phase: status held high after completion blocks the next grant
    f_echo = 1'b0;
    f_man  = 1'b0;
    fa.req = 3'b110;
    qfg.push_back(2'd1); qfg.push_back(2'd2);
    qfd.push_back(2'd1); qfd.push_back(2'd2);
    tick(1);
    fa.req = '0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (fa.ind === 1'b1) break;
    end
    f_man = 1'b1;
    tick(1);
    chk("t4_done", fa.done, 1);
    chk("t4_ind_down", fa.ind, 0);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("t4_ind_held_low", fa.ind, 0);
    end
    f_man = 1'b0;
    tick(1);
    chk("t4_no_grant_first_edge", fa.ind, 0);
    tick(1);
    chk("t4_grant_second_edge", fa.ind, 1);
    chk("t4_grant_ch", fa.ind_ch, 2);
    f_man = 1'b1;
    tick(1);
    f_man = 1'b0;
    tick(3);
    chk("t4_grants_left", qfg.size(), 0);
    chk("t4_dones_left", qfd.size(), 0);

    // Timeout on ch2 with status held low
`ifdef IND_ARB_TIMEOUT_EN
    fa.req = 3'b100;
    qfg.push_back(2'd2);
    tick(1);
    fa.req = '0;
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (fa.ind === 1'b1) hi++;
      else if (hi > 0) break;
    end
    chk("t5_ind_high_cycles", hi, 4);
    chk("t5_err", fa.err, 3'b100);
    chk("t5_no_done", fa.done, 0);
    chk("t5_pend", fa.pend, 0);
    fa.err_clr = 3'b100;
    tick(1);
    fa.err_clr = '0;
    chk("t5_err_clr", fa.err, 0);
    tick(2);
`else
    hi = 0;
    fa.req = 3'b100;
    qfg.push_back(2'd2); qfd.push_back(2'd2);
    tick(1);
    fa.req = '0;
    tick(8);
    chk("t5_ind_waits", fa.ind, 1);
    chk("t5_ind_ch", fa.ind_ch, 2);
    chk("t5_err_tied", fa.err, 0);
    f_man = 1'b1;
    tick(1);
    chk("t5_done", fa.done, 1);
    f_man = 1'b0;
    tick(2);
`endif
    chk("t5_grants_left", qfg.size(), 0);

    // Reset while ACTIVE with two channels pending
    fa.req = 3'b011;
    qfg.push_back(2'd0);
    tick(1);
    fa.req = '0;
    tick(1);
    chk("t6_active", fa.ind, 1);
    chk("t6_pend", fa.pend, 3'b011);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("t6_rst_pend", fa.pend, 0);
    chk("t6_rst_ind", fa.ind, 0);
    chk("t6_rst_ind_ch", fa.ind_ch, 0);
    chk("t6_rst_done", fa.done, 0);
    chk("t6_rst_done_ch", fa.done_ch, 0);
    chk("t6_rst_err", fa.err, 0);
    fa.req = 3'b010;
    qfg.push_back(2'd1);
    tick(1);
    fa.req = '0;
    chk("t6_pend_new", fa.pend, 3'b010);
    chk("t6_ind_not_yet", fa.ind, 0);
    tick(1);
    chk("t6_ind_up", fa.ind, 1);
    chk("t6_ind_ch", fa.ind_ch, 1);
    f_man = 1'b1;
    qfd.push_back(2'd1);
    tick(1);
    f_man = 1'b0;
    tick(3);

    chk("end_fix_grants_left", qfg.size(), 0);
    chk("end_fix_dones_left", qfd.size(), 0);
    chk("end_rr_grants_left", qrg.size(), 0);
    chk("end_rr_dones_left", qrd.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
